// File: rtl/mean_arbiter.sv
// Purpose: shares one mean unit among NUM_REQ row producers. Rows are admitted round-robin, and an in-order
//          tag FIFO returns each result to the requester that issued the row.
// Latency: adds no cycles in either direction. Handshakes pass combinationally from the registered pointers and count.
// Backpressure: issue stalls on m_in_ready=0 or on a full tag FIFO. A head requester with rsp_ready=0 blocks all returns.
// Ports:
//   clk, rst_n                                  clock, async active-low reset
//   req_valid/req_ready/req_row                 requester rows (req_ready is one-hot)
//   m_in_valid/m_in_ready/m_a_in                row path into the mean unit
//   m_out_valid/m_out_ready/m_mean/m_mean_sq    result path out of the mean unit
//   rsp_valid/rsp_ready/rsp_mean/rsp_mean_sq    one-hot result valid, broadcast result data
//   outstanding, err_orphan                     rows in flight, sticky flag for a result with no matching tag
module mean_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ROW_W     = 1024,
  parameter int TAG_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*ROW_W-1:0]     req_row,
  output logic                         m_in_valid,
  input  logic                         m_in_ready,
  output logic [ROW_W-1:0]             m_a_in,
  input  logic [15:0]                  m_mean,
  input  logic [31:0]                  m_mean_sq,
  input  logic                         m_out_valid,
  output logic                         m_out_ready,
  output logic [NUM_REQ-1:0]           rsp_valid,
  input  logic [NUM_REQ-1:0]           rsp_ready,
  output logic [15:0]                  rsp_mean,
  output logic [31:0]                  rsp_mean_sq,
  output logic [$clog2(TAG_DEPTH):0]   outstanding,
  output logic                         err_orphan
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int AW = $clog2(TAG_DEPTH);
  localparam int CW = AW + 1;

  logic          run;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] grant;
  logic          found;
  logic [IW:0]   rr_sum;

  logic [IW-1:0] tag_mem [TAG_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [IW-1:0] head;

  logic tag_full;
  logic tag_empty;
  logic can_issue;
  logic issue_fire;
  logic ret_fire;

  assign tag_full  = (count == CW'(TAG_DEPTH));
  assign tag_empty = (count == '0);
  assign can_issue = run & m_in_ready & ~tag_full;

  // Search the requesters starting at rr_ptr. The loop walks the offsets backwards,
  // so the smallest offset that has a valid request is the one that wins.
  always_comb begin
    grant  = '0;
    found  = 1'b0;
    rr_sum = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      rr_sum = {1'b0, rr_ptr} + (IW+1)'(k);
      if (rr_sum >= (IW+1)'(NUM_REQ)) rr_sum = rr_sum - (IW+1)'(NUM_REQ);
      if (req_valid[rr_sum[IW-1:0]]) begin
        grant = rr_sum[IW-1:0];
        found = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (can_issue & found) req_ready[grant] = 1'b1;
  end

  assign m_in_valid = can_issue & found;
  assign m_a_in     = found ? req_row[grant*ROW_W +: ROW_W] : '0;
  assign issue_fire = m_in_valid & m_in_ready;

  // Return side. The mean unit is in-order, so the FIFO head always names the owner of the current result.
  assign head = tag_mem[rd_ptr];

  always_comb begin
    rsp_valid = '0;
    if (run & m_out_valid & ~tag_empty) rsp_valid[head] = 1'b1;
  end

  // With no tags pending, any result is an orphan. It is accepted and dropped so the unit cannot lock up.
  assign m_out_ready = run & (tag_empty | rsp_ready[head]);
  assign ret_fire    = m_out_valid & m_out_ready & ~tag_empty;

  assign rsp_mean    = m_mean;
  assign rsp_mean_sq = m_mean_sq;
  assign outstanding = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run        <= 1'b0;
      rr_ptr     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      err_orphan <= 1'b0;
    end else begin
      run <= 1'b1;
      if (issue_fire) begin
        wr_ptr <= wr_ptr + 1'b1;
        rr_ptr <= (grant == IW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
      end
      if (ret_fire) rd_ptr <= rd_ptr + 1'b1;
      // A push and a pop in the same cycle leave the count unchanged.
      if (issue_fire & ~ret_fire)      count <= count + 1'b1;
      else if (ret_fire & ~issue_fire) count <= count - 1'b1;
      if (run & m_out_valid & tag_empty) err_orphan <= 1'b1;
    end
  end

  // Tag storage has no reset. Reset clears the count and pointers, which makes every stored entry invalid.
  always_ff @(posedge clk) begin
    if (issue_fire) tag_mem[wr_ptr] <= grant;
  end

endmodule

// File: tb/tb_mean_arbiter.sv
module tb_mean_arbiter;

  localparam int N   = 4;
  localparam int W   = 1024;
  localparam int D   = 16;
  localparam int LAT = 10;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_row;
  logic             m_in_valid;
  logic             m_in_ready;
  logic [W-1:0]     m_a_in;
  logic [15:0]      m_mean;
  logic [31:0]      m_mean_sq;
  logic             m_out_valid;
  logic             m_out_ready;
  logic [N-1:0]     rsp_valid;
  logic [N-1:0]     rsp_ready;
  logic [15:0]      rsp_mean;
  logic [31:0]      rsp_mean_sq;
  logic [4:0]       outstanding;
  logic             err_orphan;

  always #5 clk = ~clk;

  mean_arbiter #(.NUM_REQ(N), .ROW_W(W), .TAG_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_row(req_row),
    .m_in_valid(m_in_valid), .m_in_ready(m_in_ready), .m_a_in(m_a_in),
    .m_mean(m_mean), .m_mean_sq(m_mean_sq), .m_out_valid(m_out_valid), .m_out_ready(m_out_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_mean(rsp_mean), .rsp_mean_sq(rsp_mean_sq),
    .outstanding(outstanding), .err_orphan(err_orphan)
  );

  typedef struct { int req; logic [15:0] mean; logic [31:0] msq; } exp_t;
  typedef struct { int rdy; logic [15:0] mean; logic [31:0] msq; } stub_t;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model state
  int     tag_q[$];
  exp_t   sb_q[$];
  stub_t  stub_q[$];
  int     glog[$];
  int     rr_m = 0;
  bit     run_m = 0;
  bit     err_m = 0;
  int     cyc = 0;

  // Stimulus controls
  logic [15:0]  row_v[N];
  bit           consumed[N];
  int           left[N];
  int           pv = 100, pin = 100, prr = 100;
  logic [N-1:0] rr_mask = '1;
  bit           directed = 0;
  bit           force_orphan = 0;

  always_comb begin
    for (int i = 0; i < N; i++) req_row[i*W +: W] = {64{row_v[i]}};
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (low 64 bits)", nm, act[63:0], exp[63:0]);
  endtask

  function automatic logic [15:0] next_val(int i);
    if (directed) return 16'h0100 * 16'(i + 1);
    return 16'($urandom_range(1, 32'h7fff));
  endfunction

  // Compare DUT outputs with the model's pre-edge state, then advance the model across the next edge.
  task automatic check_and_update();
    int cnt, g, idx, dummy;
    bit can, fire_iss, e_mor;
    logic [N-1:0] e_rr, e_rv;
    logic [W-1:0] e_row;
    longint s, sq;
    shortint x;
    stub_t st;
    cnt = tag_q.size();
    can = run_m && m_in_ready && (cnt < D);
    g = -1;
    for (int k = 0; k < N; k++) begin
      idx = (rr_m + k) % N;
      if (g < 0 && req_valid[idx]) g = idx;
    end
    e_rr = '0;
    if (can && g >= 0) e_rr[g] = 1'b1;
    e_row = '0;
    if (g >= 0) e_row = {64{row_v[g]}};
    e_rv = '0;
    if (run_m && m_out_valid && cnt > 0) e_rv[tag_q[0]] = 1'b1;
    e_mor = 1'b0;
    if (run_m) begin
      if (cnt == 0) e_mor = 1'b1;
      else e_mor = rsp_ready[tag_q[0]];
    end
    chk("req_ready", req_ready, e_rr);
    chk("m_in_valid", m_in_valid, can && g >= 0);
    chk("m_a_in", m_a_in, e_row);
    chk("rsp_valid", rsp_valid, e_rv);
    chk("m_out_ready", m_out_ready, e_mor);
    chk("outstanding", outstanding, cnt);
    chk("err_orphan", err_orphan, err_m);
    chk("rsp_mean_pass", {rsp_mean_sq, rsp_mean}, {m_mean_sq, m_mean});

    // Stub mean unit: it reacts to the real handshakes on its own ports.
    if (m_in_valid && m_in_ready) begin
      s = 0; sq = 0;
      for (int e = 0; e < 64; e++) begin
        x = shortint'(m_a_in[e*16 +: 16]);
        s += longint'(x);
        sq += longint'(x) * longint'(x);
      end
      st.rdy = cyc + LAT; st.mean = 16'(s >>> 6); st.msq = 32'(sq >>> 6);
      stub_q.push_back(st);
    end
    if (m_out_valid && m_out_ready && stub_q.size() > 0 && stub_q[0].rdy <= cyc)
      dummy = stub_q.pop_front().rdy;

    if (!rst_n) return;
    fire_iss = can && g >= 0;
    if (fire_iss) begin
      tag_q.push_back(g);
      sb_q.push_back('{g, row_v[g], 32'(row_v[g]) * 32'(row_v[g])});
      rr_m = (g + 1) % N;
      consumed[g] = 1;
      if (left[g] > 0) left[g]--;
      glog.push_back(g);
    end
    if (m_out_valid && e_mor && cnt > 0) dummy = tag_q.pop_front();
    if (run_m && m_out_valid && cnt == 0) err_m = 1;
    run_m = 1;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (consumed[i]) begin row_v[i] = next_val(i); consumed[i] = 0; end
      req_valid[i] = (left[i] != 0) && ($urandom_range(99) < pv);
      rsp_ready[i] = rr_mask[i] && ($urandom_range(99) < prr);
    end
    m_in_ready = ($urandom_range(99) < pin);
    if (force_orphan) begin
      m_out_valid = 1'b1; m_mean = 16'h5a5a; m_mean_sq = 32'hdeadbeef;
    end else if (rst_n && stub_q.size() > 0 && stub_q[0].rdy <= cyc) begin
      m_out_valid = 1'b1; m_mean = stub_q[0].mean; m_mean_sq = stub_q[0].msq;
    end else begin
      m_out_valid = 1'b0; m_mean = 16'($urandom); m_mean_sq = $urandom;
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_and_update();
    @(posedge clk);
    #1;
    cyc++;
    drive();
  endtask

  task automatic drain();
    for (int i = 0; i < N; i++) left[i] = 0;
    rr_mask = '1; prr = 100;
    for (int n = 0; n < 400 && (tag_q.size() > 0 || stub_q.size() > 0); n++) step();
    step(); step();
    #2;
    chk("drained_outstanding", outstanding, 0);
  endtask

  // Scoreboard monitor: every accepted result must go to the next issued row's requester and carry its statistics.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < N; i++) begin
        if (rsp_valid[i] && rsp_ready[i]) begin
          if (sb_q.size() == 0) begin
            n_chk++;
            $display("FAIL rsp_unexpected: requester %0d got a result, none pending", i);
          end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("rsp_requester", i, e.req);
            chk("rsp_mean", rsp_mean, e.mean);
            chk("rsp_mean_sq", rsp_mean_sq, e.msq);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    int exp_g[8];
    req_valid = '0; rsp_ready = '0; m_in_ready = 1'b0; m_out_valid = 1'b0;
    m_mean = '0; m_mean_sq = '0;
    for (int i = 0; i < N; i++) begin row_v[i] = next_val(i); consumed[i] = 0; left[i] = -1; end

    // Reset: requests present and the unit ready, yet nothing may be granted.
    repeat (3) step();
    #2;
    chk("reset_req_ready", req_ready, 0);
    chk("reset_outstanding", outstanding, 0);
    rst_n = 1'b1;

    // 1: requester 0 alone sends two rows back-to-back.
    for (int i = 0; i < N; i++) left[i] = 0;
    left[0] = 2;
    glog.delete();
    repeat (25) step();
    chk("t1_issues", glog.size(), 2);
    drain();

    // 2: all requesters continuously valid, row i filled with 0x0100*(i+1).
    directed = 1;
    for (int i = 0; i < N; i++) begin row_v[i] = next_val(i); left[i] = -1; end
    repeat (40) step();
    drain();
    directed = 0;

    // 3: requester 2 refuses results until the tag FIFO fills.
    for (int i = 0; i < N; i++) left[i] = -1;
    rr_mask = 4'b1011;
    repeat (60) step();
    #2;
    chk("t3_outstanding_full", outstanding, D);
    chk("t3_req_ready", req_ready, 0);
    chk("t3_m_out_ready", m_out_ready, 0);
    rr_mask = '1;
    repeat (20) step();
    drain();

    // 4: unit presents a result with nothing outstanding.
    force_orphan = 1;
    step();
    force_orphan = 0;
    repeat (5) step();
    #2;
    chk("t4_err_orphan_sticky", err_orphan, 1);

    // 5: reset with five rows in flight.
    for (int i = 0; i < N; i++) left[i] = 1;
    left[0] = 2;
    rr_mask = '0;
    repeat (20) step();
    #2;
    chk("t5_outstanding_before", outstanding, 5);
    rst_n = 1'b0;
    m_out_valid = 1'b0;
    tag_q.delete(); sb_q.delete(); stub_q.delete();
    rr_m = 0; run_m = 0; err_m = 0;
    #2;
    chk("t5_outstanding_reset", outstanding, 0);
    chk("t5_rsp_valid_reset", rsp_valid, 0);
    chk("t5_err_reset", err_orphan, 0);
    rr_mask = '1;
    repeat (2) step();
    rst_n = 1'b1;

    // 6: round-robin restarts at 0, then the rr_ptr=3 / req1-only case, then reqs 0 and 3 together.
    glog.delete();
    for (int i = 0; i < N; i++) left[i] = 1;
    repeat (7) step();
    left[2] = 1;
    repeat (3) step();
    left[1] = 1;
    repeat (3) step();
    left[0] = 1; left[3] = 1;
    repeat (4) step();
    exp_g = '{0, 1, 2, 3, 2, 1, 3, 0};
    chk("t6_grant_count", glog.size(), 8);
    for (int k = 0; k < 8 && k < glog.size(); k++) chk("t6_grant_order", glog[k], exp_g[k]);
    drain();

    // Random traffic with stalls on every interface.
    for (int i = 0; i < N; i++) left[i] = -1;
    pv = 60; pin = 70; prr = 75;
    repeat (1500) step();
    pv = 100; pin = 100;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
